threewire_arbiter: RTL and testbench
====================================

# threewire_arbiter

Round-robin arbiter that shares one `threewire_master_ctrl` instance between `NUM_REQ` independent requesters. It latches the winning requester's command and drives the master's start/mode/addr/data inputs. It follows the master's `out_io_in_progress` handshake and returns read data plus a one-cycle completion or error pulse to the requester. It sits between the register-access clients and the three-wire master, on the same clock as the master.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TWA_ADDRESS_BITS`, 10: address width, equal to the master's `TWM_ADDRESS_BITS`.
- `TWA_DATA_BITS`, 32: data width, equal to the master's `TWM_DATA_BITS`.
- `TWA_START_TIMEOUT`, 255: number of cycles `START` waits for the master busy flag before aborting; 0 disables the timeout.

- `in_clk`  in  1  system clock, shared with the master.
- `in_rst_n`  in  1  asynchronous, active-low reset.
- `in_req`  in  NUM_REQ  per-requester request level.
- `in_mode_wr`  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- `in_addr`  in  NUM_REQ*TWA_ADDRESS_BITS  packed addresses; requester k occupies slice `[k*A +: A]`.
- `in_wr_data`  in  NUM_REQ*TWA_DATA_BITS  packed write data; requester k occupies slice `[k*D +: D]`.
- `out_grant`  out  NUM_REQ  one-hot owner of the current transaction; all zeros when idle.
- `out_ack`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `out_err`  out  NUM_REQ  one-cycle timeout pulse to the owner.
- `out_rd_data`  out  TWA_DATA_BITS  data from the last completed read.
- `out_busy`  out  1  high whenever the state is not `IDLE`.
- `out_tw_start`  out  1  drives the master's `in_start`.
- `out_tw_mode_wr`  out  1  drives the master's `in_mode_wr`.
- `out_tw_addr`  out  TWA_ADDRESS_BITS  drives the master's `in_addr`.
- `out_tw_wr_data`  out  TWA_DATA_BITS  drives the master's `in_wr_data`.
- `in_tw_rd_data`  in  TWA_DATA_BITS  from the master's `out_rd_data`.
- `in_tw_busy`  in  1  from the master's `out_io_in_progress`.

## Operation
- FSM states: `IDLE`, `START`, `BUSY`, `DONE`.
- **IDLE → START.** Taken when any `in_req` bit is 1.
  - The winner is the first requester with `req=1`, searching upward from the round-robin pointer `ptr` and wrapping modulo `NUM_REQ`.
  - On this transition the winner's mode, address and write data are registered into the `out_tw_*` outputs, and `out_grant` is set to the winner.
- **START.**
  - `out_tw_start` is 1.
  - On `in_tw_busy=1`: go to `BUSY`.
  - If `TWA_START_TIMEOUT` cycles elapse in `START` without `in_tw_busy=1`: pulse `out_err[g]` for one cycle, then go to `IDLE`.
- **BUSY.**
  - `out_tw_start` is 0.
  - On `in_tw_busy=0`: go to `DONE`.
  - If the transaction is a read, `out_rd_data` captures `in_tw_rd_data` on this transition. A write leaves `out_rd_data` unchanged.
- **DONE.** Lasts one cycle and always returns to `IDLE`.
  - `out_ack[g]` is 1.
  - `out_grant` clears.
- **Round-robin pointer.** On leaving `DONE` or timing out, `ptr` becomes (g+1) mod `NUM_REQ`. `ptr` resets to 0.
- **Latched commands.** The requester's inputs are sampled only at grant. Changes to a requester's inputs after grant do not affect the transaction in flight.
- **Withdrawn requests.** Dropping `in_req` after grant does not abort the transaction; ack still pulses.
- **Request re-assertion.** A requester whose `req` is still 1 in the cycle after its ack is treated as a new request, arbitrated behind all others.
- **Stable outputs.** `out_tw_mode_wr`, `out_tw_addr` and `out_tw_wr_data` hold their values from grant until the next grant.

## Timing
- **Reset.** Entered asynchronously on `in_rst_n=0`, even mid-transaction: state `IDLE`, `ptr=0`, timeout counter 0. All outputs are 0: `out_grant`, `out_ack`, `out_err`, `out_busy`, `out_tw_start`, `out_rd_data`, `out_tw_mode_wr`, `out_tw_addr` and `out_tw_wr_data`. Reset release is synchronous to `in_clk`; the first grant can occur on the first edge after release.
- **Request to start.** A request seen in `IDLE` at edge t gives `out_grant` and `out_tw_start` = 1 after edge t.
- **Start drop.** `out_tw_start` falls on the edge following the first sampled `in_tw_busy=1`.
- **Completion.** `out_ack` is high for exactly the one cycle after the edge that samples `in_tw_busy=0` in `BUSY`. `out_rd_data` is valid in that same cycle and held until the next read completes.
- **Back-to-back.** `IDLE` occupies at least one cycle between transactions. Re-arbitration therefore happens on the edge that follows the ack cycle.
- **Timeout counter.** Width is ceil(log2(`TWA_START_TIMEOUT`+1)). It clears on entering `START` and saturates; the abort occurs when it reaches `TWA_START_TIMEOUT`.
- **Simultaneous events.**
  - `out_ack` and `out_err` are never high together.
  - A new `in_req` arriving during `START`, `BUSY` or `DONE` waits in `IDLE` for arbitration.
  - `in_tw_busy` already high in `IDLE` is ignored.

## Test plan
- **Single write.** Requester 2 writes addr 0x333, data 0xAABBCCDD. The `tw_slave` model must capture addr 0x333, data 0xAABBCCDD, mode 1. `out_ack=4'b0100` for one cycle.
- **Single read.** Requester 0 reads addr 0x2AA, with the slave returning 0x00112233. `out_rd_data` must equal 0x00112233 in the ack cycle, with `out_ack=4'b0001`.
- **Round-robin fairness.** All four requests are held high continuously. Grant order must be 0,1,2,3,0; no requester is granted twice before the others are served.
- **Timeout.** `in_tw_busy` is tied low, `TWA_START_TIMEOUT=8`, and requester 1 requests. `out_err=4'b0010` must pulse after 8 `START` cycles, then `IDLE`, with no ack.
- **Reset mid-BUSY.** `in_rst_n` is pulled low during a read. All outputs must go 0 immediately. After release, requester 3 is granted next only if it is the lowest index requesting from ptr=0.
- **Command latching.** Requester 0 changes `in_addr` from 0x001 to 0x3FF one cycle after grant. The slave must receive 0x001.

Source files
------------

// File: rtl/threewire_arbiter_if.sv
// Bundle between the requesters / three-wire master and the arbiter.
// The arbiter takes the slave view; the environment holds the master view.
interface threewire_arbiter_if #(
   parameter int NUM_REQ          = 4,
   parameter int TWA_ADDRESS_BITS = 10,
   parameter int TWA_DATA_BITS    = 32
);
   logic [NUM_REQ-1:0]                  in_req;
   logic [NUM_REQ-1:0]                  in_mode_wr;
   logic [NUM_REQ*TWA_ADDRESS_BITS-1:0] in_addr;
   logic [NUM_REQ*TWA_DATA_BITS-1:0]    in_wr_data;
   logic [NUM_REQ-1:0]                  out_grant;
   logic [NUM_REQ-1:0]                  out_ack;
   logic [NUM_REQ-1:0]                  out_err;
   logic [TWA_DATA_BITS-1:0]            out_rd_data;
   logic                                out_busy;
   logic                                out_tw_start;
   logic                                out_tw_mode_wr;
   logic [TWA_ADDRESS_BITS-1:0]         out_tw_addr;
   logic [TWA_DATA_BITS-1:0]            out_tw_wr_data;
   logic [TWA_DATA_BITS-1:0]            in_tw_rd_data;
   logic                                in_tw_busy;

   modport slave (
      input  in_req, in_mode_wr, in_addr, in_wr_data, in_tw_rd_data, in_tw_busy,
      output out_grant, out_ack, out_err, out_rd_data, out_busy,
             out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data
   );

   modport master (
      output in_req, in_mode_wr, in_addr, in_wr_data, in_tw_rd_data, in_tw_busy,
      input  out_grant, out_ack, out_err, out_rd_data, out_busy,
             out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data
   );
endinterface

// File: rtl/threewire_arbiter.sv
// Round-robin arbiter sharing one three-wire master among NUM_REQ requesters.
// Commands are latched at grant; ack/err pulse for one cycle to the owner.
module threewire_arbiter #(
   parameter int NUM_REQ           = 4,
   parameter int TWA_ADDRESS_BITS  = 10,
   parameter int TWA_DATA_BITS     = 32,
   parameter int TWA_START_TIMEOUT = 255
) (
   input logic                in_clk,
   input logic                in_rst_n,
   threewire_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TWA_START_TIMEOUT > 0) ? $clog2(TWA_START_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_V = CW'(TWA_START_TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      ptr, gidx, gidx_inc, win_idx;
   logic               win_vld;
   logic [CW-1:0]      cnt;
   logic               timeout;
   logic [NUM_REQ-1:0] g_oh;

   // first requester at or above ptr, wrapping
   always_comb begin
      logic [IW-1:0] cand;
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IW'((int'(ptr) + i) % NUM_REQ);
         if (!win_vld && bus.in_req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign gidx_inc = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   assign timeout  = (TWA_START_TIMEOUT != 0) && (cnt == TO_V);
   assign g_oh     = NUM_REQ'(1) << gidx;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (win_vld) state_nxt = START;
         START: begin
            if (timeout)            state_nxt = IDLE;
            else if (bus.in_tw_busy) state_nxt = BUSY;
         end
         BUSY:  if (!bus.in_tw_busy) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.out_busy     = (state != IDLE);
   assign bus.out_tw_start = (state == START);
   assign bus.out_grant    = (state == START || state == BUSY) ? g_oh : '0;
   assign bus.out_ack      = (state == DONE) ? g_oh : '0;
   assign bus.out_err      = (state == START && timeout) ? g_oh : '0;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state              <= IDLE;
         ptr                <= '0;
         gidx               <= '0;
         cnt                <= '0;
         bus.out_tw_mode_wr <= 1'b0;
         bus.out_tw_addr    <= '0;
         bus.out_tw_wr_data <= '0;
         bus.out_rd_data    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && win_vld) begin
            gidx               <= win_idx;
            cnt                <= '0;
            bus.out_tw_mode_wr <= bus.in_mode_wr[win_idx];
            bus.out_tw_addr    <= bus.in_addr[int'(win_idx)*TWA_ADDRESS_BITS +: TWA_ADDRESS_BITS];
            bus.out_tw_wr_data <= bus.in_wr_data[int'(win_idx)*TWA_DATA_BITS +: TWA_DATA_BITS];
         end else if (state == START && cnt != TO_V) begin
            cnt <= cnt + 1'b1;
         end
         if (state == BUSY && !bus.in_tw_busy && !bus.out_tw_mode_wr)
            bus.out_rd_data <= bus.in_tw_rd_data;
         if (state == DONE || (state == START && timeout))
            ptr <= gidx_inc;
      end
   end
endmodule

// File: tb/tb_threewire_arbiter.sv
// Bench for threewire_arbiter: vector table plus scoreboard, with a small
// three-wire slave model answering start with a fixed-latency busy window.
module tb_threewire_arbiter;
   localparam int N  = 4;
   localparam int A  = 10;
   localparam int D  = 32;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   threewire_arbiter_if #(.NUM_REQ(N), .TWA_ADDRESS_BITS(A), .TWA_DATA_BITS(D)) bif ();

   threewire_arbiter #(
      .NUM_REQ(N), .TWA_ADDRESS_BITS(A), .TWA_DATA_BITS(D), .TWA_START_TIMEOUT(TO)
   ) dut (
      .in_clk(clk),
      .in_rst_n(rst_n),
      .bus(bif)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // slave model
   logic         slave_en = 1'b1;
   logic [D-1:0] sl_rd    = '0;
   logic [A-1:0] cap_addr = '0;
   logic [D-1:0] cap_data = '0;
   logic         cap_mode = 1'b0;
   int           sl_cnt   = 0;

   initial begin
      bif.in_tw_busy    = 1'b0;
      bif.in_tw_rd_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bif.in_tw_busy = 1'b0;
            sl_cnt = 0;
         end else if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
               bif.in_tw_busy    = 1'b0;
               bif.in_tw_rd_data = sl_rd;
            end
         end else if (slave_en && bif.out_tw_start && !bif.in_tw_busy) begin
            cap_addr       = bif.out_tw_addr;
            cap_data       = bif.out_tw_wr_data;
            cap_mode       = bif.out_tw_mode_wr;
            bif.in_tw_busy = 1'b1;
            sl_cnt         = 3;
         end
      end
   end

   // scoreboard
   typedef struct {
      logic [N-1:0] ack;
      logic [N-1:0] err;
      logic [D-1:0] rd;
      logic [A-1:0] addr;
      logic [D-1:0] wd;
      logic         mode;
      logic         chk_slave;
   } exp_t;

   exp_t         sb[$];
   logic [D-1:0] last_rd = '0;

   task automatic push(input int r, input logic mode, input logic [A-1:0] addr,
                       input logic [D-1:0] wd, input logic [D-1:0] rresp);
      exp_t e;
      e.ack = '0; e.ack[r] = 1'b1;
      e.err = '0;
      if (!mode) last_rd = rresp;
      e.rd = last_rd; e.addr = addr; e.wd = wd; e.mode = mode; e.chk_slave = 1'b1;
      sb.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (bif.out_ack != '0 || bif.out_err != '0)) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {bif.out_ack, bif.out_err}, 0);
            end else begin
               e = sb.pop_front();
               chk("ack", bif.out_ack, e.ack);
               chk("err", bif.out_err, e.err);
               chk("rd_data", bif.out_rd_data, e.rd);
               if (e.chk_slave) begin
                  chk("slave_addr", cap_addr, e.addr);
                  chk("slave_data", cap_data, e.wd);
                  chk("slave_mode", cap_mode, e.mode);
               end
            end
         end
      end
   end

   task automatic drive_cmd(input int r, input logic mode, input logic [A-1:0] addr,
                            input logic [D-1:0] wd);
      bif.in_mode_wr[r]         = mode;
      bif.in_addr[r*A +: A]     = addr;
      bif.in_wr_data[r*D +: D]  = wd;
   endtask

   task automatic wait_resp(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bif.out_ack != '0 || bif.out_err != '0) ok = 1'b1;
      end
      if (!ok) chk({"wait_", name}, 0, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"}, bif.out_grant, 0);
      chk({tag, "_ack"}, bif.out_ack, 0);
      chk({tag, "_err"}, bif.out_err, 0);
      chk({tag, "_busy"}, bif.out_busy, 0);
      chk({tag, "_start"}, bif.out_tw_start, 0);
      chk({tag, "_rd"}, bif.out_rd_data, 0);
      chk({tag, "_mode"}, bif.out_tw_mode_wr, 0);
      chk({tag, "_addr"}, bif.out_tw_addr, 0);
      chk({tag, "_wdata"}, bif.out_tw_wr_data, 0);
   endtask

   typedef struct {
      int           r;
      logic         mode;
      logic [A-1:0] addr;
      logic [D-1:0] wd;
      logic [D-1:0] rresp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[5];
      int st;
      bit seen;
      vecs[0] = '{2, 1'b1, 10'h333, 32'hAABBCCDD, 32'h0};
      vecs[1] = '{0, 1'b0, 10'h2AA, 32'h0,        32'h00112233};
      vecs[2] = '{1, 1'b1, 10'h000, 32'hFFFFFFFF, 32'h0};
      vecs[3] = '{3, 1'b0, 10'h3FF, 32'h0,        32'hDEADBEEF};
      vecs[4] = '{1, 1'b0, 10'h155, 32'h0,        32'h0};
      order   = '{0, 1, 2, 3, 0};

      bif.in_req = '0; bif.in_mode_wr = '0; bif.in_addr = '0; bif.in_wr_data = '0;
      #12;
      chk_zero("reset");
      @(negedge clk); #1 rst_n = 1'b1;

      // single transactions from the table
      foreach (vecs[v]) begin
         @(negedge clk);
         drive_cmd(vecs[v].r, vecs[v].mode, vecs[v].addr, vecs[v].wd);
         sl_rd = vecs[v].rresp;
         push(vecs[v].r, vecs[v].mode, vecs[v].addr, vecs[v].wd, vecs[v].rresp);
         bif.in_req[vecs[v].r] = 1'b1;
         @(negedge clk);
         chk("vec_grant", bif.out_grant, 64'(1) << vecs[v].r);
         chk("vec_start", bif.out_tw_start, 1);
         wait_resp("vec");
         bif.in_req[vecs[v].r] = 1'b0;
      end

      // round robin from ptr=0 with everyone requesting
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1; last_rd = '0;
      for (int k = 0; k < N; k++) drive_cmd(k, 1'b1, A'(10'h10 + k), D'(32'h100 + k));
      foreach (order[n]) push(order[n], 1'b1, A'(10'h10 + order[n]), D'(32'h100 + order[n]), '0);
      bif.in_req = '1;
      foreach (order[n]) begin
         wait_resp("rr");
         chk("rr_order", bif.out_ack, 64'(1) << order[n]);
      end
      bif.in_req = '0;

      // start timeout: slave silent
      @(negedge clk);
      slave_en = 1'b0;
      begin
         exp_t e;
         e.ack = '0; e.err = 4'b0010; e.rd = last_rd;
         e.addr = '0; e.wd = '0; e.mode = 1'b0; e.chk_slave = 1'b0;
         sb.push_back(e);
      end
      drive_cmd(1, 1'b1, 10'h077, 32'h77);
      bif.in_req[1] = 1'b1;
      st = 0; seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bif.out_err != '0) seen = 1'b1;
         else if (bif.out_tw_start) st++;
      end
      chk("timeout_seen", seen, 1);
      chk("timeout_start_cycles", st, TO);
      bif.in_req[1] = 1'b0;
      slave_en = 1'b1;
      @(negedge clk);
      chk("timeout_idle", bif.out_busy, 0);
      chk("timeout_no_ack", bif.out_ack, 0);

      // reset during BUSY of a read
      @(negedge clk);
      drive_cmd(1, 1'b0, 10'h0AB, 32'h0);
      sl_rd = 32'h12345678;
      bif.in_req[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bif.in_tw_busy && bif.out_busy && !bif.out_tw_start) seen = 1'b1;
      end
      chk("midrst_reached_busy", seen, 1);
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      sb.delete();
      last_rd = '0;
      bif.in_req = '0;
      @(negedge clk); #1;
      drive_cmd(3, 1'b1, 10'h0C3, 32'h33);
      push(1, 1'b0, 10'h0AB, 32'h0, 32'h12345678);
      push(3, 1'b1, 10'h0C3, 32'h33, '0);
      bif.in_req = 4'b1010;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_grant", bif.out_grant, 4'b0010);
      wait_resp("postrst1");
      bif.in_req[1] = 1'b0;
      wait_resp("postrst3");
      bif.in_req[3] = 1'b0;

      // command latching: address changes after grant
      @(negedge clk);
      drive_cmd(0, 1'b1, 10'h001, 32'h5A5A5A5A);
      push(0, 1'b1, 10'h001, 32'h5A5A5A5A, '0);
      bif.in_req[0] = 1'b1;
      @(negedge clk);
      chk("latch_grant", bif.out_grant, 4'b0001);
      bif.in_addr[0 +: A] = 10'h3FF;
      @(negedge clk);
      chk("latch_tw_addr", bif.out_tw_addr, 10'h001);
      wait_resp("latch");
      bif.in_req[0] = 1'b0;
      @(negedge clk);
      chk("latch_hold_addr", bif.out_tw_addr, 10'h001);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
